// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
  localparam logic [31:0] PC_INC        = 32'd4;

endpackage

// File: rtl/instruction_fetch_if.sv
// Bundle of fetch-stage signals: instruction memory port, execute redirect, IF/ID output.
interface instruction_fetch_if;
  import fetch_pkg::*;

  logic [31:0]  imem_pc;
  logic [31:0]  imem_instr;
  logic         redirect_valid;
  logic [31:0]  redirect_pc;
  // id_valid/id_ready: a word moves to decode on every rising edge where both are high;
  // while id_valid is high and id_ready low, id_pc/id_instr are held stable.
  logic         id_ready;
  logic         id_valid;
  logic [31:0]  id_pc;
  logic [31:0]  id_instr;
  logic         fetch_fault;
  logic         halted;
  fetch_state_e state;

  modport master (
    output imem_pc, id_valid, id_pc, id_instr, fetch_fault, halted, state,
    input  imem_instr, redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_pc, id_valid, id_pc, id_instr, fetch_fault, halted, state,
    output imem_instr, redirect_valid, redirect_pc, id_ready
  );

endinterface

// File: rtl/if_id_register.sv
// IF/ID pipeline register: load from fetch, flush on redirect, NOP fill once decode takes the word.
module if_id_register #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic        flush_i,
  input  logic        ready_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o
);

  logic        valid_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      pc_q    <= 32'd0;
      instr_q <= NOP_INSTR;
    end else if (flush_i) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
    end else if (load_i) begin
      valid_q <= 1'b1;
      pc_q    <= pc_i;
      instr_q <= instr_i;
    end else if (valid_q && ready_i) begin
      // decode consumed the word and nothing replaced it
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign instr_o = instr_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, captures {pc, instr} into IF/ID, handles redirects and end-of-image halt.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter int unsigned IMEM_BYTES = 128,
  parameter logic [31:0] NOP_INSTR  = NOP_INSTR_DEF
) (
  input  logic                clk,
  input  logic                reset,
  instruction_fetch_if.master bus
);

  localparam logic [32:0] LAST_WORD = 33'(IMEM_BYTES - 4);

  logic [31:0]  pc_q, pc_d;
  fetch_state_e state_q, state_d;
  logic         fault_q, fault_d;

  logic         id_valid;
  logic         redirect_take;
  logic         capture;
  logic [31:0]  redirect_aligned;
  logic [32:0]  pc_next_wide;

  assign redirect_take    = bus.redirect_valid && (state_q != ST_BOOT);
  assign capture          = (state_q == ST_RUN) && !bus.redirect_valid &&
                            (!id_valid || bus.id_ready);
  assign redirect_aligned = {bus.redirect_pc[31:2], 2'b00};
  // 33-bit sum so a PC near the top of the address space cannot wrap
  assign pc_next_wide     = {1'b0, pc_q} + {1'b0, PC_INC};

  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    fault_d = 1'b0;
    if (redirect_take) begin
      pc_d = redirect_aligned;
      if (bus.redirect_pc[1:0] != 2'b00) begin
        fault_d = 1'b1;
        state_d = ST_RUN;
      end else if ({1'b0, bus.redirect_pc} > LAST_WORD) begin
        fault_d = 1'b1;
        state_d = ST_HALT;
      end else begin
        state_d = ST_RUN;
      end
    end else begin
      case (state_q)
        ST_BOOT: state_d = ST_RUN;
        ST_RUN: begin
          if (capture) begin
            // the last word is still delivered; the PC parks on it
            if (pc_next_wide <= LAST_WORD) pc_d = pc_next_wide[31:0];
            else                           state_d = ST_HALT;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      state_q <= ST_BOOT;
      fault_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
      fault_q <= fault_d;
    end
  end

  if_id_register #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk     (clk),
    .reset   (reset),
    .load_i  (capture),
    .flush_i (redirect_take),
    .ready_i (bus.id_ready),
    .pc_i    (pc_q),
    .instr_i (bus.imem_instr),
    .valid_o (id_valid),
    .pc_o    (bus.id_pc),
    .instr_o (bus.id_instr)
  );

  assign bus.imem_pc     = pc_q;
  assign bus.id_valid    = id_valid;
  assign bus.fetch_fault = fault_q;
  assign bus.halted      = (state_q == ST_HALT);
  assign bus.state       = state_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a transfer scoreboard fed from a local memory image.
module tb_instruction_fetch;
  import fetch_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  instruction_fetch_if bus ();

  instruction_fetch dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] mem [0:31];
  logic [63:0] exp_q[$];
  logic [63:0] mon_e;
  int total = 0;
  int bad = 0;

  assign bus.imem_instr = (bus.imem_pc < 32'd128) ? mem[bus.imem_pc[6:2]] : 32'hFFFF_FFFF;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a);
    exp_q.push_back({a, mem[a[6:2]]});
  endtask

  // scoreboard: every transfer to decode must match the next expected word
  always @(negedge clk) begin
    if (!reset && bus.id_valid && bus.id_ready) begin
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_xfer: got pc %h want no transfer", bus.id_pc);
      end
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("xfer_pc", bus.id_pc, mon_e[63:32]);
        chk("xfer_instr", bus.id_instr, mon_e[31:0]);
      end
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = {8'hC0, 8'(i), 16'h0033};
    mem[0] = 32'h0020_81B3;
    mem[1] = 32'h0020_91B3;
    mem[8] = 32'h4020_A1B3;

    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'd0;
    bus.id_ready       = 1'b1;
    reset              = 1'b1;
    tick();
    tick();
    chk("rst_id_valid", 32'(bus.id_valid), 32'd0);
    chk("rst_id_pc", bus.id_pc, 32'd0);
    chk("rst_id_instr", bus.id_instr, 32'h0000_0013);
    chk("rst_imem_pc", bus.imem_pc, 32'd0);
    chk("rst_fault", 32'(bus.fetch_fault), 32'd0);
    chk("rst_halted", 32'(bus.halted), 32'd0);
    chk("rst_state", 32'(bus.state), 32'(ST_BOOT));

    reset = 1'b0;
    push(32'h0);
    tick();
    chk("boot_state", 32'(bus.state), 32'(ST_RUN));
    chk("boot_no_capture", 32'(bus.id_valid), 32'd0);
    push(32'h4);
    tick();
    chk("first_valid", 32'(bus.id_valid), 32'd1);
    chk("first_pc", bus.id_pc, 32'h0);
    chk("first_instr", bus.id_instr, 32'h0020_81B3);
    chk("first_imem_pc", bus.imem_pc, 32'h4);
    tick();
    chk("second_pc", bus.id_pc, 32'h4);
    chk("second_instr", bus.id_instr, 32'h0020_91B3);

    bus.id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc", bus.id_pc, 32'h4);
      chk("stall_instr", bus.id_instr, 32'h0020_91B3);
      chk("stall_imem_pc", bus.imem_pc, 32'h8);
    end
    bus.id_ready = 1'b1;
    push(32'h8);
    tick();
    chk("resume_pc", bus.id_pc, 32'h8);
    chk("resume_imem_pc", bus.imem_pc, 32'hC);

    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h20;
    tick();
    chk("redir_flush", 32'(bus.id_valid), 32'd0);
    chk("redir_imem_pc", bus.imem_pc, 32'h20);
    chk("redir_nofault", 32'(bus.fetch_fault), 32'd0);
    bus.redirect_valid = 1'b0;
    push(32'h20);
    tick();
    chk("redir_id_pc", bus.id_pc, 32'h20);
    chk("redir_id_instr", bus.id_instr, 32'h4020_A1B3);

    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h22;
    tick();
    chk("misalign_fault", 32'(bus.fetch_fault), 32'd1);
    chk("misalign_imem_pc", bus.imem_pc, 32'h20);
    chk("misalign_state", 32'(bus.state), 32'(ST_RUN));
    bus.redirect_valid = 1'b0;
    push(32'h20);
    tick();
    chk("misalign_fault_pulse", 32'(bus.fetch_fault), 32'd0);
    chk("misalign_id_pc", bus.id_pc, 32'h20);

    for (int a = 32'h24; a <= 32'h7C; a += 4) push(32'(a));
    for (int n = 0; n < 40 && !bus.halted; n++) tick();
    chk("halt_reached", 32'(bus.halted), 32'd1);
    chk("halt_last_pc", bus.id_pc, 32'h7C);
    chk("halt_imem_pc", bus.imem_pc, 32'h7C);
    tick();
    chk("halt_drain_valid", 32'(bus.id_valid), 32'd0);
    chk("halt_drain_instr", bus.id_instr, 32'h0000_0013);
    repeat (3) tick();
    chk("halt_hold_valid", 32'(bus.id_valid), 32'd0);
    chk("halt_hold_pc", bus.imem_pc, 32'h7C);

    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0;
    tick();
    chk("unhalt_halted", 32'(bus.halted), 32'd0);
    chk("unhalt_imem_pc", bus.imem_pc, 32'h0);
    bus.redirect_valid = 1'b0;
    push(32'h0);
    tick();
    chk("unhalt_capture", bus.id_pc, 32'h0);

    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h80;
    tick();
    chk("range_fault", 32'(bus.fetch_fault), 32'd1);
    chk("range_halted", 32'(bus.halted), 32'd1);
    chk("range_imem_pc", bus.imem_pc, 32'h80);
    bus.redirect_pc = 32'h10;
    tick();
    chk("range_exit_fault", 32'(bus.fetch_fault), 32'd0);
    chk("range_exit_halted", 32'(bus.halted), 32'd0);
    chk("range_exit_pc", bus.imem_pc, 32'h10);
    bus.redirect_valid = 1'b0;
    bus.id_ready       = 1'b0;
    tick();
    chk("load_no_ready", bus.id_pc, 32'h10);
    tick();
    chk("stall2_imem_pc", bus.imem_pc, 32'h14);

    reset              = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h30;
    tick();
    chk("midrst_valid", 32'(bus.id_valid), 32'd0);
    chk("midrst_imem_pc", bus.imem_pc, 32'h0);
    chk("midrst_state", 32'(bus.state), 32'(ST_BOOT));
    reset        = 1'b0;
    bus.id_ready = 1'b1;
    tick();
    chk("boot_redir_ignored", bus.imem_pc, 32'h0);
    chk("boot_redir_nofault", 32'(bus.fetch_fault), 32'd0);
    bus.redirect_valid = 1'b0;
    push(32'h0);
    tick();
    chk("post_rst_pc", bus.id_pc, 32'h0);
    tick();
    chk("post_rst_next", bus.id_pc, 32'h4);
    bus.id_ready = 1'b0;
    tick();
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
